// File: rtl/spi_pkg.sv
// spi_pkg: shared widths, idle word and FSM states
// for the SPI mode-0 target (spi_slave).
package spi_pkg;

  localparam int SPI_DATA_W = 8;

  localparam logic [7:0] SPI_IDLE_WORD = 8'h00;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT
  } spi_slv_state_e;

  function automatic int cnt_w(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// spi_pin_sync: 2-FF synchroniser + edge register for one async pin.
// Ports: clk, rst (async, active-low), pin -> lvl, rise, fall (1-clk pulses).
module spi_pin_sync
  import spi_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= RST_VAL;
      s2 <= RST_VAL;
      s3 <= RST_VAL;
    end else begin
      s1 <= pin;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign lvl  = s2;
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

endmodule

// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 target, MSB first, oversampled by clk.
// Ports: clk, rst (async, active-low); SCLK/MOSI/SS_n in, MISO/miso_oe out;
//   tx_data/tx_valid/tx_ready (1-entry holding reg);
//   rx_data/rx_valid, busy, tx_underrun.
// Option: SPI_SLAVE_ECHO_EN -> underrun words echo last rx_data.
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W,
  parameter logic [DATA_W-1:0] IDLE_WORD =
    DATA_W'(SPI_IDLE_WORD)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SCLK,
  input  logic              MOSI,
  input  logic              SS_n,
  output logic              MISO,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              tx_underrun
);

  localparam int CW = cnt_w(DATA_W);
  localparam logic [CW-1:0] LAST =
    CW'(DATA_W - 1);

  spi_slv_state_e state;
  spi_slv_state_e state_nx;

  logic sclk_lvl;
  logic sclk_rise;
  logic sclk_fall;
  logic mosi_lvl;
  logic mosi_rise;
  logic mosi_fall;
  logic ss_lvl;
  logic ss_rise;
  logic ss_fall;

  logic [CW-1:0]     bit_cnt;
  logic [DATA_W-2:0] rx_sh;
  logic [DATA_W-2:0] tx_sh;
  logic [DATA_W-1:0] hold;
  logic              hold_full;
  logic [DATA_W-1:0] fill;
  logic [DATA_W-1:0] tx_word;
  logic              capture;
  logic              reload;
  logic              unused_ok;

  spi_pin_sync #(.RST_VAL(1'b0)) u_sclk (
    .clk  (clk),
    .rst  (rst),
    .pin  (SCLK),
    .lvl  (sclk_lvl),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_pin_sync #(.RST_VAL(1'b0)) u_mosi (
    .clk  (clk),
    .rst  (rst),
    .pin  (MOSI),
    .lvl  (mosi_lvl),
    .rise (mosi_rise),
    .fall (mosi_fall)
  );

  // SS_n idles high, so its synchroniser resets high
  spi_pin_sync #(.RST_VAL(1'b1)) u_ss (
    .clk  (clk),
    .rst  (rst),
    .pin  (SS_n),
    .lvl  (ss_lvl),
    .rise (ss_rise),
    .fall (ss_fall)
  );

  assign unused_ok =
    ^{sclk_lvl, mosi_rise, mosi_fall};

`ifdef SPI_SLAVE_ECHO_EN
  assign fill = rx_data;
`else
  assign fill = IDLE_WORD;
`endif

  assign busy     = ~ss_lvl;
  assign tx_ready = ~hold_full;
  assign capture  = tx_valid & ~hold_full;
  assign tx_word  = hold_full ? hold : fill;

  // word start: LOAD, or the SCLK fall that
  // closes a word; deselect always wins
  assign reload = ~ss_rise & (
    (state == LOAD) |
    ((state == SHIFT) & sclk_fall &
     (bit_cnt == '0)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (ss_fall) begin
          state_nx = LOAD;
        end
      end
      LOAD: begin
        state_nx = ss_rise ? IDLE : SHIFT;
      end
      SHIFT: begin
        if (ss_rise) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold      <= '0;
      hold_full <= 1'b0;
    end else if (capture) begin
      // new word stays held even if a
      // reload happens in the same clk
      hold      <= tx_data;
      hold_full <= 1'b1;
    end else if (reload) begin
      hold_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      MISO        <= 1'b0;
      miso_oe     <= 1'b0;
      bit_cnt     <= '0;
      rx_sh       <= '0;
      tx_sh       <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      if (ss_rise) begin
        MISO    <= 1'b0;
        miso_oe <= 1'b0;
        bit_cnt <= '0;
      end else if (reload) begin
        tx_sh       <= tx_word[DATA_W-2:0];
        MISO        <= tx_word[DATA_W-1];
        miso_oe     <= 1'b1;
        tx_underrun <= ~hold_full;
      end else begin
        unique case (state)
          IDLE: begin
            MISO    <= 1'b0;
            miso_oe <= 1'b0;
            bit_cnt <= '0;
          end
          SHIFT: begin
            if (sclk_rise) begin
              rx_sh <= {rx_sh[DATA_W-3:0],
                        mosi_lvl};
              if (bit_cnt == LAST) begin
                rx_data  <= {rx_sh, mosi_lvl};
                rx_valid <= 1'b1;
                bit_cnt  <= '0;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else if (sclk_fall) begin
              MISO  <= tx_sh[DATA_W-2];
              tx_sh <= {tx_sh[DATA_W-3:0],
                        1'b0};
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed mode-0 master driving spi_slave,
// checked with immediate assertions.
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       rst;
  logic       SCLK;
  logic       MOSI;
  logic       SS_n;
  logic       MISO;
  logic       miso_oe;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       tx_underrun;

  int checks   = 0;
  int failures = 0;
  int rx_cnt   = 0;
  int ur_cnt   = 0;
  int rdy_hi   = 0;

  always #5 clk = ~clk;

  spi_slave dut (
    .clk         (clk),
    .rst         (rst),
    .SCLK        (SCLK),
    .MOSI        (MOSI),
    .SS_n        (SS_n),
    .MISO        (MISO),
    .miso_oe     (miso_oe),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .busy        (busy),
    .tx_underrun (tx_underrun)
  );

  always @(posedge clk) begin
    if (rx_valid) rx_cnt++;
    if (tx_underrun) ur_cnt++;
    if (tx_ready) rdy_hi++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bits(input logic [7:0] m,
                      input int n,
                      output logic [7:0] g);
    g = '0;
    for (int i = 7; i > 7 - n; i--) begin
      MOSI = m[i];
      tick(5);
      g[i] = MISO;
      SCLK = 1'b1;
      tick(5);
      SCLK = 1'b0;
    end
  endtask

  task automatic push(input logic [7:0] d);
    int n = 0;
    while (!tx_ready && n < 400) begin
      tick(1);
      n++;
    end
    chk("push_ready", 32'(tx_ready), 1);
    tx_data  = d;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
  endtask

  task automatic sel();
    SS_n = 1'b0;
    tick(8);
  endtask

  task automatic desel();
    tick(6);
    SS_n = 1'b1;
    tick(6);
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, "_miso"}, 32'(MISO), 0);
    chk({tag, "_oe"}, 32'(miso_oe), 0);
    chk({tag, "_txrdy"}, 32'(tx_ready), 1);
    chk({tag, "_rxdata"}, 32'(rx_data), 0);
    chk({tag, "_rxvld"}, 32'(rx_valid), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_ur"}, 32'(tx_underrun), 0);
  endtask

  initial begin
    logic [7:0] g;
    logic [7:0] g2;
    logic [7:0] prev;
    int r0;
    int u0;

    rst      = 1'b0;
    SCLK     = 1'b0;
    MOSI     = 1'b0;
    SS_n     = 1'b1;
    tx_valid = 1'b0;
    tx_data  = '0;
    tick(3);
    rst_chk("reset");
    rst = 1'b1;
    tick(3);

    // 1: single word
    push(8'hA5);
    chk("t1_txrdy_full", 32'(tx_ready), 0);
    r0 = rx_cnt;
    sel();
    chk("t1_busy", 32'(busy), 1);
    chk("t1_oe", 32'(miso_oe), 1);
    bits(8'h3C, 8, g);
    desel();
    chk("t1_miso", 32'(g), 32'hA5);
    chk("t1_rxdata", 32'(rx_data), 32'h3C);
    chk("t1_rxcnt", rx_cnt - r0, 1);
    chk("t1_busy_off", 32'(busy), 0);
    chk("t1_oe_off", 32'(miso_oe), 0);

    // 2: back-to-back words
    push(8'h12);
    r0 = rx_cnt;
    sel();
    fork
      begin
        bits(8'h56, 8, g);
        bits(8'h9A, 8, g2);
      end
      push(8'h34);
    join
    desel();
    chk("t2_miso0", 32'(g), 32'h12);
    chk("t2_miso1", 32'(g2), 32'h34);
    chk("t2_rxcnt", rx_cnt - r0, 2);
    chk("t2_rxdata", 32'(rx_data), 32'h9A);

    // 3: underrun twice
    prev = rx_data;
    u0   = ur_cnt;
    sel();
    bits(8'hF0, 8, g);
    bits(8'hF0, 8, g2);
    chk("t3_urcnt", ur_cnt - u0, 2);
    desel();
`ifdef SPI_SLAVE_ECHO_EN
    chk("t3_miso0", 32'(g), 32'(prev));
    chk("t3_miso1", 32'(g2), 32'hF0);
`else
    chk("t3_miso0", 32'(g), 32'h00);
    chk("t3_miso1", 32'(g2), 32'h00);
`endif
    chk("t3_rxdata", 32'(rx_data), 32'hF0);

    // 4: abort after 5 bits
    prev = rx_data;
    r0   = rx_cnt;
    sel();
    bits(8'hA3, 5, g);
    SS_n = 1'b1;
    tick(4);
    chk("t4_oe_off", 32'(miso_oe), 0);
    chk("t4_busy_off", 32'(busy), 0);
    tick(4);
    chk("t4_rxcnt", rx_cnt - r0, 0);
    chk("t4_rxdata", 32'(rx_data), 32'(prev));
    push(8'hC3);
    sel();
    bits(8'h5A, 8, g);
    desel();
    chk("t4_clean_miso", 32'(g), 32'hC3);
    chk("t4_clean_rx", 32'(rx_data), 32'h5A);

    // 5: async reset mid-word
    push(8'h7E);
    sel();
    bits(8'h24, 4, g);
    MOSI = 1'b1;
    tick(2);
    rst = 1'b0;
    #1;
    rst_chk("t5_arst");
    SS_n = 1'b1;
    tick(4);
    rst = 1'b1;
    tick(4);
    push(8'h81);
    r0 = rx_cnt;
    sel();
    bits(8'h81, 8, g);
    desel();
    chk("t5_miso", 32'(g), 32'h81);
    chk("t5_rxdata", 32'(rx_data), 32'h81);
    chk("t5_rxcnt", rx_cnt - r0, 1);

    // 6: tx_valid held across reload
    push(8'hAA);
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    rdy_hi   = 0;
    sel();
    bits(8'h11, 8, g);
    tx_valid = 1'b0;
    chk("t6_rdy_cycles", rdy_hi, 1);
    chk("t6_txrdy", 32'(tx_ready), 0);
    bits(8'h22, 8, g2);
    desel();
    chk("t6_miso0", 32'(g), 32'hAA);
    chk("t6_miso1", 32'(g2), 32'h55);
    chk("t6_rxdata", 32'(rx_data), 32'h22);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
